// File: rtl/ay8913_envelope_gen.sv
`default_nettype none
// ============================================================================
// Module   : ay8913_envelope_gen
// Brief    : AY-3-8913 envelope generator. A prescaler clock-enable drives a
//            period divider; each divider wrap advances a shape state machine
//            that produces the 5-bit envelope level.
// Macro    : AY_ENV_32STEP_EN - YM2149-style 32-step envelope. The prescaler
//            ticks twice as often, so the full cycle time is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module ay8913_envelope_gen #(
  parameter int PERIOD_BITS  = 16,
  parameter int PRESCALE_DIV = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [3:0]             shape,
  input  logic                   restart,
  output logic [4:0]             level,
  output logic                   holding,
  output logic                   step
);

`ifdef AY_ENV_32STEP_EN
  localparam int IDX_W     = 5;
  localparam int PRE_TICKS = PRESCALE_DIV / 2;
`else
  localparam int IDX_W     = 4;
  localparam int PRE_TICKS = PRESCALE_DIV;
`endif
  localparam int PRE_W = (PRE_TICKS > 1) ? $clog2(PRE_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // shape field decode
  logic shp_continue, shp_attack, shp_alternate, shp_hold;
  assign shp_continue  = shape[3];
  assign shp_attack    = shape[2];
  assign shp_alternate = shape[1];
  assign shp_hold      = shape[0];

  logic [0:0]             state, next_state;
  logic [PRE_W-1:0]       presc;
  logic [PERIOD_BITS-1:0] pcnt;
  logic [IDX_W-1:0]       idx;
  logic                   dir;

  logic                   tick;
  logic                   fire;
  logic                   end_cycle;
  logic [PERIOD_BITS-1:0] period_m1;
  logic [IDX_W-1:0]       idx_inc;

  logic [IDX_W-1:0]       idx_nxt;
  logic                   dir_nxt;
  logic [IDX_W-1:0]       v_nxt;
  logic                   load_level;
  logic                   step_nxt;
  logic [4:0]             level_map;

  assign tick      = (presc == PRE_MAX);
  // A zero period behaves as a period of one.
  assign period_m1 = (period == '0) ? '0 : period - 1'b1;
  // >= so that a period lowered below the current count fires on the next tick.
  assign fire      = tick && (pcnt >= period_m1);
  assign end_cycle = (idx == IDX_MAX);
  assign idx_inc   = idx + 1'b1;
  assign holding   = (state == ST_HOLD);

`ifdef AY_ENV_32STEP_EN
  assign level_map = v_nxt;
`else
  assign level_map = {v_nxt, v_nxt[3]};
`endif

  // Prescaler and period divider; both free-run in every state.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pcnt <= (pcnt >= period_m1) ? '0 : pcnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_HOLD;
    else       state <= next_state;
  end

  // Next state: restart always runs; a completed cycle holds unless continuing.
  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = ST_RUN;
    end else if (state == ST_RUN && fire && end_cycle &&
                 !(shp_continue && !shp_hold)) begin
      next_state = ST_HOLD;
    end
  end

  // Step/level decode: next index, direction and base value for this cycle.
  always_comb begin
    idx_nxt    = idx;
    dir_nxt    = dir;
    v_nxt      = '0;
    load_level = 1'b0;
    step_nxt   = 1'b0;
    if (restart) begin
      idx_nxt    = '0;
      dir_nxt    = shp_attack;
      v_nxt      = shp_attack ? '0 : IDX_MAX;
      load_level = 1'b1;
    end else if (state == ST_RUN && fire) begin
      load_level = 1'b1;
      step_nxt   = 1'b1;
      if (!end_cycle) begin
        idx_nxt = idx_inc;
        v_nxt   = dir ? idx_inc : IDX_MAX - idx_inc;
      end else if (!shp_continue) begin
        v_nxt = '0;
      end else if (shp_hold) begin
        v_nxt = (dir ? IDX_MAX : '0) ^ {IDX_W{shp_alternate}};
      end else begin
        idx_nxt = '0;
        dir_nxt = dir ^ shp_alternate;
        v_nxt   = dir_nxt ? '0 : IDX_MAX;
      end
    end
  end

  // Datapath registers: index, direction, level and step pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      dir   <= 1'b0;
      level <= '0;
      step  <= 1'b0;
    end else begin
      idx  <= idx_nxt;
      dir  <= dir_nxt;
      step <= step_nxt;
      if (load_level) level <= level_map;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ay8913_envelope_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ay8913_envelope_gen
// Brief    : Directed bench for ay8913_envelope_gen (16-step build,
//            PRESCALE_DIV=16). Expected step gaps/levels are queued when the
//            stimulus is applied and compared on each step pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ay8913_envelope_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] period = 16'd1;
  logic [3:0]  shape = 4'd0;
  logic        restart = 1'b0;
  logic [4:0]  level;
  logic        holding;
  logic        step;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int gap;
    int lvl;
    int hld;
  } exp_t;

  exp_t sb[$];

  ay8913_envelope_gen #(.PERIOD_BITS(16), .PRESCALE_DIV(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .period  (period),
    .shape   (shape),
    .restart (restart),
    .level   (level),
    .holding (holding),
    .step    (step)
  );

  always #5 clk = ~clk;

  // 4-bit base value to 5-bit level: v*2 with the top bit copied into bit 0.
  function automatic int map16(input int v);
    return v * 2 + v / 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int gap, input int lvl, input int hld);
    exp_t e;
    e.gap = gap;
    e.lvl = lvl;
    e.hld = hld;
    sb.push_back(e);
  endtask

  // Pop each expectation and wait (bounded) for the matching step pulse.
  task automatic drain(input string tag);
    exp_t e;
    int   n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n = 0;
      do begin
        tick();
        n++;
      end while (step !== 1'b1 && n < e.gap + 4);
      check({tag, "_gap"}, n, e.gap);
      check({tag, "_level"}, {27'd0, level}, e.lvl);
      check({tag, "_holding"}, {31'd0, holding}, e.hld);
    end
  endtask

  // Run n cycles expecting no step pulse and unchanged outputs.
  task automatic quiet(input string tag, input int n, input int lvl, input int hld);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (step !== 1'b0) pulses++;
    end
    check({tag, "_nostep"}, pulses, 0);
    check({tag, "_level"}, {27'd0, level}, lvl);
    check({tag, "_holding"}, {31'd0, holding}, hld);
  endtask

  task automatic do_restart(input logic [3:0] shp, input logic [15:0] per);
    shape   = shp;
    period  = per;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick();
    tick();
    check("reset_level", {27'd0, level}, 0);
    check("reset_holding", {31'd0, holding}, 1);
    check("reset_step", {31'd0, step}, 0);
    reset = 1'b0;
    quiet("idle", 1000, 0, 1);

    // Sawtooth up, period 1
    do_restart(4'b1100, 16'd1);
    check("saw_start", {27'd0, level}, 0);
    check("saw_run", {31'd0, holding}, 0);
    for (int v = 1; v <= 15; v++) push(16, map16(v), 0);
    push(16, 0, 0);
    drain("saw");

    // One-shot decay, period 2
    do_restart(4'b0000, 16'd2);
    check("decay_start", {27'd0, level}, 31);
    for (int v = 14; v >= 0; v--) push(32, map16(v), 0);
    push(32, 0, 1);
    drain("decay");
    quiet("decay_hold", 100, 0, 1);

    // Decay then hold max
    do_restart(4'b1011, 16'd1);
    check("s11_start", {27'd0, level}, 31);
    for (int v = 14; v >= 0; v--) push(16, map16(v), 0);
    push(16, 31, 1);
    drain("s11");
    quiet("s11_hold", 50, 31, 1);

    // Rise then hold max
    do_restart(4'b1101, 16'd1);
    check("s13_start", {27'd0, level}, 0);
    for (int v = 1; v <= 15; v++) push(16, map16(v), 0);
    push(16, 31, 1);
    drain("s13");

    // Triangle, period 0 treated as 1
    do_restart(4'b1110, 16'd0);
    check("tri_start", {27'd0, level}, 0);
    for (int v = 1; v <= 15; v++) push(16, map16(v), 0);
    push(16, 31, 0);
    for (int v = 14; v >= 0; v--) push(16, map16(v), 0);
    push(16, 0, 0);
    drain("tri");

    // Restart coincident with a firing step
    do_restart(4'b1000, 16'd1);
    for (int i = 0; i < 15; i++) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("coinc_level", {27'd0, level}, 31);
    check("coinc_step", {31'd0, step}, 0);
    check("coinc_holding", {31'd0, holding}, 0);
    push(16, map16(14), 0);
    drain("coinc");

    // Period lowered mid-count
    do_restart(4'b1100, 16'd100);
    quiet("plong", 80, 0, 0);
    period = 16'd3;
    push(16, map16(1), 0);
    push(48, map16(2), 0);
    drain("pshort");

    // Reset in the middle of a cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_level", {27'd0, level}, 0);
    check("midrst_holding", {31'd0, holding}, 1);
    check("midrst_step", {31'd0, step}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
